alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle successor to the combinational ALU.
- Accepts operations over a valid/ready handshake and returns a registered result plus flags over a second valid/ready handshake.
- Single-cycle ops take 1 cycle. An iterative shift-add multiply (ALU_MUL) takes WIDTH cycles.
- Sits between the decode/issue stage and writeback of the CPU datapath.

Parameters:
- WIDTH, 8: operand/result width in bits; must be ≥ 2.
- SHW, $clog2(WIDTH): derived; shift-amount bits taken from in2[SHW-1:0].

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort: drop any in-flight op or held result.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B / shift amount.
- alu_op  in  alu_opcode_t  operation select.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  registered result.
- flags  out  alu_flags_t  registered {zero, negative, carry, overflow}.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, out=0, flags=0, multiplier registers=0. in_ready=1 once rst deasserts.
- States: IDLE, BUSY, DONE.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out/flags hold stable while out_valid=1 and out_ready=0.
  - in_ready = (state==IDLE) || (state==DONE && out_ready) — back-to-back issue with no bubble.
- Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA): op accepted at edge N; result registered at that edge; out_valid=1 in cycle N+1. Transition to DONE.
- ALU_MUL: operands latched at edge N, state→BUSY. One partial-product step per cycle, WIDTH steps total. out_valid=1 in cycle N+WIDTH. out = low WIDTH bits of the unsigned product.
- DONE: on output transfer → IDLE. If a new op is accepted in the same cycle, follow that op's path instead (DONE→DONE, or DONE→BUSY for MUL).
- Flag rules:
  - zero = (out==0); negative = out[WIDTH-1]; applies to all ops.
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: carry = borrow (in1 < in2 unsigned); overflow = signed overflow.
  - AND/OR/XOR: carry=0, overflow=0.
  - SLL/SRL/SRA: carry = last bit shifted out (0 if amount=0); overflow=0.
  - MUL: carry = overflow = (high half of product != 0).
- Boundary cases:
  - Shift amount uses only in2[SHW-1:0]; upper bits ignored.
  - SRA replicates in1[WIDTH-1].
  - Undefined opcode: out=0, flags=0, 1-cycle latency.
  - flush=1 has priority over everything: next state IDLE, out_valid=0, in_ready=0 in the flush cycle; an input offered in that cycle is not accepted.
  - rst mid-MUL: immediate return to reset values; no result is produced.

Optional Feature:
- Macro: ALU_MC_MUL_EN.
- Defined: ALU_MUL supported as above; BUSY state and iterative multiplier instantiated.
- Undefined: no multiplier logic and no BUSY state. ALU_MUL treated as an undefined opcode (out=0, flags=0, 1-cycle latency).

Decomposition:
- defs_pkg:
  - Add ALU_MUL to alu_opcode_t (always present so encoding is stable).
  - Add alu_mc_state_t enum {IDLE, BUSY, DONE}.
  - alu_flags_t unchanged.
- Sub-module alu_mul_iter (under ALU_MC_MUL_EN): start/done shift-add unit, WIDTH-cycle latency, 2*WIDTH product.
- Reuse the existing combinational alu for single-cycle ops.

Test Plan (WIDTH=8):
- ADD 0x7F+0x01, out_ready=1 → out_valid next cycle; out=0x80, N=1, V=1, C=0, Z=0.
- SUB 0x00-0x01 issued back-to-back after ADD 0xFF+0x01 → consecutive out_valid cycles; out=0x00 (Z=1, C=1), then out=0xFF (C=1, N=1); in_ready never drops.
- MUL 0x10*0x10 → out_valid exactly 8 cycles after accept; out=0x00, Z=1, C=V=1; in_ready=0 during BUSY. MUL 0x0F*0x03 → out=0x2D, C=V=0.
- SLL 0x81 by 0x09 (amount 1) with out_ready=0 for 3 cycles → out=0x02, C=1 held stable until out_ready=1, then IDLE.
- flush at MUL step 4 → out_valid never asserts; IDLE next cycle. rst pulse mid-MUL → all outputs 0 immediately.
- Without ALU_MC_MUL_EN: ALU_MUL 0x03*0x03 → 1-cycle, out=0x00, flags=0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   alu_opcode_t   - operation select; ALU_MUL is always encoded so opcode
//                    values do not move when the multiplier is compiled out.
//   alu_mc_state_t - control states of alu_mc.
//   alu_flags_t    - {zero, negative, carry, overflow}.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_MUL = 4'd8
  } alu_opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_mc_state_t;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_mc_mul_iter.sv
// alu_mc_mul_iter: iterative shift-add unsigned multiplier, one partial
// product per cycle, WIDTH cycles from start to done.
//   start      - load operands a/b (ignored while flush is high)
//   flush      - abandon any multiply in progress
//   done_c     - high in the cycle the final step is applied
//   product_c  - full 2*WIDTH product, valid while done_c is high
module alu_mc_mul_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done_c,
  output logic [2*WIDTH-1:0]   product_c
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    step_c;

  // The last step is folded in combinationally so the product is ready
  // exactly WIDTH edges after the load edge.
  assign step_c    = mplier_q[0] ? mcand_q : '0;
  assign product_c = acc_q + step_c;
  assign done_c    = busy_q && (cnt_q == CW'(1));

  // Next-state for the shift-add datapath
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (start) begin
      acc_d    = '0;
      mcand_d  = PW'(a);
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = product_c;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (done_c) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU with valid/ready on both sides.
//   clk, rst (async, active-high), flush (synchronous abort)
//   in_valid/in_ready, in1, in2, alu_op - operation request
//   out_valid/out_ready, out, flags      - registered result and flags
// Build option: define ALU_MC_MUL_EN to include the iterative multiplier
// (ALU_MUL, WIDTH-cycle latency). Without it ALU_MUL behaves like an
// undefined opcode.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  alu_opcode_t      alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output alu_flags_t       flags
);

  localparam int unsigned XW = WIDTH + 1;

  alu_mc_state_t    state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  alu_flags_t       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic             in_fire_c;
  logic [SHW-1:0]   amt_c;
  logic [XW-1:0]    sum_c, diff_c, sll_c, srl_c, sra_c;
  logic [WIDTH-1:0] res_c;
  logic             cy_c, ov_c, def_c;
  alu_flags_t       flg_c;

  // Back-to-back issue: a held result leaving this cycle frees the slot.
  assign in_ready  = !flush && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
  assign in_fire_c = in_valid && in_ready;

  // Single-cycle operations; shifts are widened by one bit so the
  // last bit shifted out falls into the extra position.
  always_comb begin
    amt_c  = in2[SHW-1:0];
    sum_c  = {1'b0, in1} + {1'b0, in2};
    diff_c = {1'b0, in1} - {1'b0, in2};
    sll_c  = {1'b0, in1} << amt_c;
    srl_c  = {in1, 1'b0} >> amt_c;
    sra_c  = XW'($signed({in1, 1'b0}) >>> amt_c);
    res_c  = '0;
    cy_c   = 1'b0;
    ov_c   = 1'b0;
    def_c  = 1'b1;
    case (alu_op)
      ALU_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        cy_c  = sum_c[WIDTH];
        ov_c  = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum_c[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = diff_c[WIDTH-1:0];
        cy_c  = diff_c[WIDTH];
        ov_c  = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_c[WIDTH-1] != in1[WIDTH-1]);
      end
      ALU_AND: res_c = in1 & in2;
      ALU_OR:  res_c = in1 | in2;
      ALU_XOR: res_c = in1 ^ in2;
      ALU_SLL: begin
        res_c = sll_c[WIDTH-1:0];
        cy_c  = sll_c[WIDTH];
      end
      ALU_SRL: begin
        res_c = srl_c[WIDTH:1];
        cy_c  = srl_c[0];
      end
      ALU_SRA: begin
        res_c = sra_c[WIDTH:1];
        cy_c  = sra_c[0];
      end
      default: def_c = 1'b0;
    endcase
    flg_c.zero     = def_c && (res_c == '0);
    flg_c.negative = res_c[WIDTH-1];
    flg_c.carry    = cy_c;
    flg_c.overflow = ov_c;
  end

`ifdef ALU_MC_MUL_EN
  logic               mul_start_c;
  logic               mul_done_c;
  logic [2*WIDTH-1:0] mul_prod_c;
  logic               mul_hi_c;

  alu_mc_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (mul_start_c),
    .a         (in1),
    .b         (in2),
    .done_c    (mul_done_c),
    .product_c (mul_prod_c)
  );

  assign mul_hi_c = |mul_prod_c[2*WIDTH-1:WIDTH];
`endif

  // Next-state and result capture
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    flags_d     = flags_q;
    out_valid_d = out_valid_q;
`ifdef ALU_MC_MUL_EN
    mul_start_c = 1'b0;
`endif
    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if ((state_q == S_DONE) && out_ready) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
          end
          if (in_fire_c) begin
`ifdef ALU_MC_MUL_EN
            if (alu_op == ALU_MUL) begin
              state_d     = S_BUSY;
              out_valid_d = 1'b0;
              mul_start_c = 1'b1;
            end else
`endif
            begin
              state_d     = S_DONE;
              out_d       = res_c;
              flags_d     = flg_c;
              out_valid_d = 1'b1;
            end
          end
        end
`ifdef ALU_MC_MUL_EN
        S_BUSY: begin
          if (mul_done_c) begin
            state_d          = S_DONE;
            out_d            = mul_prod_c[WIDTH-1:0];
            flags_d.zero     = (mul_prod_c[WIDTH-1:0] == '0);
            flags_d.negative = mul_prod_c[WIDTH-1];
            flags_d.carry    = mul_hi_c;
            flags_d.overflow = mul_hi_c;
            out_valid_d      = 1'b1;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc (WIDTH=8). Directed cases plus
// randomized operations with random consumer back-pressure.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int unsigned W   = 8;
  localparam int          MOD = 256;
`ifdef ALU_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in1, in2, out;
  alu_opcode_t  alu_op;
  alu_flags_t   flags;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_op(alu_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           acc;
    int           lat;
    bit           seen;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input alu_opcode_t op, input int a, input int b,
                                output logic [W-1:0] res, output logic [3:0] flg,
                                output int lat);
    int r, t, sa, sbv, n;
    bit c, v, def;
    logic [W-1:0] rb;
    sa  = (a >= MOD/2) ? a - MOD : a;
    sbv = (b >= MOD/2) ? b - MOD : b;
    n   = b % int'(W);
    r = 0; c = 1'b0; v = 1'b0; def = 1'b1; lat = 1;
    case (op)
      ALU_ADD: begin
        t = a + b; r = t % MOD; c = (t >= MOD);
        t = sa + sbv; v = (t > MOD/2 - 1) || (t < -(MOD/2));
      end
      ALU_SUB: begin
        r = (a - b + MOD) % MOD; c = (a < b);
        t = sa - sbv; v = (t > MOD/2 - 1) || (t < -(MOD/2));
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: begin
        r = (a << n) % MOD;
        c = (n > 0) ? (((a >> (int'(W) - n)) & 1) != 0) : 1'b0;
      end
      ALU_SRL: begin
        r = a >> n;
        c = (n > 0) ? (((a >> (n - 1)) & 1) != 0) : 1'b0;
      end
      ALU_SRA: begin
        r = (sa >>> n) & (MOD - 1);
        c = (n > 0) ? (((a >> (n - 1)) & 1) != 0) : 1'b0;
      end
      ALU_MUL: begin
        if (MUL_EN) begin
          t = a * b; r = t % MOD; c = (t >= MOD); v = c; lat = int'(W);
        end else begin
          def = 1'b0;
        end
      end
      default: def = 1'b0;
    endcase
    if (!def) r = 0;
    rb  = r[W-1:0];
    res = rb;
    flg = def ? {(rb == '0), rb[W-1], c, v} : 4'b0000;
  endfunction

  // Offer one op from a negedge; returns at the negedge after acceptance.
  task automatic issue(input alu_opcode_t op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit now);
    exp_t e;
    bit   ok;
    int   waited;
    in_valid = 1'b1; in1 = a; in2 = b; alu_op = op;
    ok = 1'b0; waited = 0;
    while (!ok && waited < 200) begin
      #4;
      if (in_ready) begin
        model(op, int'(a), int'(b), e.res, e.flg, e.lat);
        e.acc  = cyc;
        e.seen = 1'b0;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(negedge clk);
      if (!ok) waited++;
    end
    in_valid = 1'b0;
    if (now) chk("accept_no_stall", waited, 0);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Random consumer back-pressure
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) out_ready = (($urandom % 4) != 0);
    end
  end

  // Monitor: compares every presented result against the scoreboard head
  initial begin
    bit           hold_v;
    logic [W-1:0] hold_out;
    logic [3:0]   hold_flg;
    hold_v = 1'b0; hold_out = '0; hold_flg = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        hold_v = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (hold_v) begin
          chk("hold_out", int'(out), int'(hold_out));
          chk("hold_flags", int'(flags), int'(hold_flg));
        end
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          if (!sb[0].seen) begin
            sb[0].seen = 1'b1;
            chk("latency", cyc - sb[0].acc, sb[0].lat);
          end
          if (out_ready) begin
            chk("out", int'(out), int'(sb[0].res));
            chk("flags", int'(flags), int'(sb[0].flg));
            void'(sb.pop_front());
          end
        end
        hold_v   = !out_ready;
        hold_out = out;
        hold_flg = flags;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  initial begin
    bit          vbad;
    int          r;
    alu_opcode_t op;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
    alu_op = ALU_ADD; out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_in_ready", int'(in_ready), 1);
    @(negedge clk);

    // Arithmetic, back-to-back issue with no bubble
    out_ready = 1'b1;
    issue(ALU_ADD, 8'h7F, 8'h01, 1'b1);
    issue(ALU_ADD, 8'hFF, 8'h01, 1'b1);
    issue(ALU_SUB, 8'h00, 8'h01, 1'b1);
    issue(ALU_MUL, 8'h10, 8'h10, 1'b1);
`ifdef ALU_MC_MUL_EN
    vbad = 1'b0;
    for (int k = 1; k < int'(W); k++) begin
      #4 vbad |= in_ready;
      @(negedge clk);
    end
    chk("busy_in_ready", int'(vbad), 0);
`endif
    issue(ALU_MUL, 8'h0F, 8'h03, 1'b1);
    drain();

    // Held result under back-pressure, amount upper bits ignored
    out_ready = 1'b0;
    issue(ALU_SLL, 8'h81, 8'h09, 1'b1);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #4 chk("idle_after_held", int'(in_ready), 1);
    @(negedge clk);

    // Undefined opcodes and SRA sign replication
    out_ready = 1'b1;
    issue(alu_opcode_t'(4'hC), 8'h12, 8'h34, 1'b1);
    issue(ALU_MUL, 8'h03, 8'h03, 1'b1);
    issue(ALU_SRA, 8'h90, 8'h03, 1'b1);
    issue(ALU_SRL, 8'h90, 8'h00, 1'b1);
    drain();

    // Flush partway through a multiply
    out_ready = 1'b0;
    issue(ALU_MUL, 8'h55, 8'h33, 1'b1);
    repeat (2) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; alu_op = ALU_ADD; in1 = 8'h01; in2 = 8'h01;
    #4 chk("flush_in_ready", int'(in_ready), 0);
    @(negedge clk);
    sb.delete();
    flush = 1'b0; in_valid = 1'b0;
    #4 chk("flush_to_idle", int'(in_ready), 1);
    vbad = 1'b0;
    for (int k = 0; k < int'(W) + 2; k++) begin
      @(negedge clk);
      #4 vbad |= out_valid;
    end
    chk("flush_no_valid", int'(vbad), 0);
    @(negedge clk);

    // Reset partway through a multiply
    issue(ALU_MUL, 8'h0F, 8'h0F, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out", int'(out), 0);
    chk("midrst_flags", int'(flags), 0);
    sb.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 9) op = alu_opcode_t'(4'($urandom_range(9, 15)));
      else        op = alu_opcode_t'(4'(r));
      if (($urandom % 4) == 0) @(negedge clk);
      issue(op, 8'($urandom), 8'($urandom), 1'b0);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
